regfile_wb_arbiter: RTL and testbench

- Schedules write-back requests from three producers (CPU ALU, CPU load/mem, VPU scalar return) onto the register file's two CPU write ports (port 0, port 1).
- Grants up to two requests per cycle using fixed priority with anti-starvation promotion.
- Never issues two writes to the same register in one cycle.
- Sits between the CPU/VPU write-back stages and the register file write inputs; outputs are registered.

---
 rtl/regfile_wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter onto the two CPU register file write ports
//
// Schedules ALU, load (MEM) and VPU scalar write-back requests onto two
// register file write ports. Up to two grants per cycle, fixed priority
// ALU > MEM > VPU with starvation promotion for MEM and VPU. The two grants
// in one cycle never target the same register.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   {alu,mem,vpu}_req/addr/data    write-back requests, held until granted
//   {alu,mem,vpu}_gnt              combinational accept, consumed at posedge
//   wrt_addr_n/wrt_data_n/we_CPU_n registered write port n (n = 0, 1)
//   wb_stall                       some request pending and not granted
module regfile_wb_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_gnt,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_gnt,
  input  logic              vpu_req,
  input  logic [ADDR_W-1:0] vpu_addr,
  input  logic [DATA_W-1:0] vpu_data,
  output logic              vpu_gnt,
  output logic [ADDR_W-1:0] wrt_addr_0,
  output logic [DATA_W-1:0] wrt_data_0,
  output logic              we_CPU_0,
  output logic [ADDR_W-1:0] wrt_addr_1,
  output logic [DATA_W-1:0] wrt_data_1,
  output logic              we_CPU_1,
  output logic              wb_stall
);

  localparam logic [1:0]       SRC_ALU = 2'd0;
  localparam logic [1:0]       SRC_MEM = 2'd1;
  localparam logic [1:0]       SRC_VPU = 2'd2;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  mem_cnt;
  logic [CNT_W-1:0]  vpu_cnt;
  logic              mem_prom;
  logic              vpu_prom;

  logic              req_vec  [3];
  logic [ADDR_W-1:0] addr_vec [3];
  logic [DATA_W-1:0] data_vec [3];
  logic [1:0]        order    [3];

  logic              s0_vld;
  logic [1:0]        s0_src;
  logic              s1_vld;
  logic [1:0]        s1_src;

  assign req_vec[0]  = alu_req;
  assign req_vec[1]  = mem_req;
  assign req_vec[2]  = vpu_req;
  assign addr_vec[0] = alu_addr;
  assign addr_vec[1] = mem_addr;
  assign addr_vec[2] = vpu_addr;
  assign data_vec[0] = alu_data;
  assign data_vec[1] = mem_data;
  assign data_vec[2] = vpu_data;

  assign mem_prom = (mem_cnt == LIMIT);
  assign vpu_prom = (vpu_cnt == LIMIT);

  // Effective priority order, highest first. Promoted sources jump ahead of
  // everything not promoted; when both are promoted VPU goes first.
  always_comb begin
    order[0] = SRC_ALU;
    order[1] = SRC_MEM;
    order[2] = SRC_VPU;
    if (mem_prom && vpu_prom) begin
      order[0] = SRC_VPU;
      order[1] = SRC_MEM;
      order[2] = SRC_ALU;
    end else if (vpu_prom) begin
      order[0] = SRC_VPU;
      order[1] = SRC_ALU;
      order[2] = SRC_MEM;
    end else if (mem_prom) begin
      order[0] = SRC_MEM;
      order[1] = SRC_ALU;
      order[2] = SRC_VPU;
    end
  end

  // Slot 0 takes the first requester in order; slot 1 the next requester
  // whose address differs from slot 0, so one cycle never writes a register twice.
  always_comb begin
    s0_vld = 1'b0;
    s0_src = SRC_ALU;
    s1_vld = 1'b0;
    s1_src = SRC_ALU;
    for (int i = 0; i < 3; i++) begin
      if (!s0_vld && req_vec[order[i]]) begin
        s0_vld = 1'b1;
        s0_src = order[i];
      end else if (s0_vld && !s1_vld && req_vec[order[i]] &&
                   (addr_vec[order[i]] != addr_vec[s0_src])) begin
        s1_vld = 1'b1;
        s1_src = order[i];
      end
    end
    if (rst) begin
      s0_vld = 1'b0;
      s1_vld = 1'b0;
    end
  end

  assign alu_gnt = (s0_vld && s0_src == SRC_ALU) || (s1_vld && s1_src == SRC_ALU);
  assign mem_gnt = (s0_vld && s0_src == SRC_MEM) || (s1_vld && s1_src == SRC_MEM);
  assign vpu_gnt = (s0_vld && s0_src == SRC_VPU) || (s1_vld && s1_src == SRC_VPU);

  assign wb_stall = !rst && ((alu_req && !alu_gnt) ||
                             (mem_req && !mem_gnt) ||
                             (vpu_req && !vpu_gnt));

  // Write ports: an unused slot drops its enable but keeps addr/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_CPU_0   <= 1'b0;
      wrt_addr_0 <= '0;
      wrt_data_0 <= '0;
      we_CPU_1   <= 1'b0;
      wrt_addr_1 <= '0;
      wrt_data_1 <= '0;
    end else begin
      we_CPU_0 <= s0_vld;
      we_CPU_1 <= s1_vld;
      if (s0_vld) begin
        wrt_addr_0 <= addr_vec[s0_src];
        wrt_data_0 <= data_vec[s0_src];
      end
      if (s1_vld) begin
        wrt_addr_1 <= addr_vec[s1_src];
        wrt_data_1 <= data_vec[s1_src];
      end
    end
  end

  // Starvation counters: count waiting cycles, saturate at the limit,
  // clear on grant or withdrawal.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cnt <= '0;
      vpu_cnt <= '0;
    end else begin
      if (mem_req && !mem_gnt) begin
        if (mem_cnt != LIMIT) mem_cnt <= mem_cnt + CNT_W'(1);
      end else begin
        mem_cnt <= '0;
      end
      if (vpu_req && !vpu_gnt) begin
        if (vpu_cnt != LIMIT) vpu_cnt <= vpu_cnt + CNT_W'(1);
      end else begin
        vpu_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_req, mem_req, vpu_req;
  logic [4:0]  alu_addr, mem_addr, vpu_addr;
  logic [15:0] alu_data, mem_data, vpu_data;
  logic        alu_gnt, mem_gnt, vpu_gnt;
  logic [4:0]  wrt_addr_0, wrt_addr_1;
  logic [15:0] wrt_data_0, wrt_data_1;
  logic        we_CPU_0, we_CPU_1;
  logic        wb_stall;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(
    .ADDR_W(5), .DATA_W(16), .STARVE_LIMIT(4), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .vpu_req(vpu_req), .vpu_addr(vpu_addr), .vpu_data(vpu_data), .vpu_gnt(vpu_gnt),
    .wrt_addr_0(wrt_addr_0), .wrt_data_0(wrt_data_0), .we_CPU_0(we_CPU_0),
    .wrt_addr_1(wrt_addr_1), .wrt_data_1(wrt_data_1), .we_CPU_1(we_CPU_1),
    .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_req = 1'b0; mem_req = 1'b0; vpu_req = 1'b0;
    alu_addr = '0;  mem_addr = '0;  vpu_addr = '0;
    alu_data = '0;  mem_data = '0;  vpu_data = '0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 3; c++) begin
      settle();
      check_eq("idle_gnt_stall", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b0000);
      check_eq("idle_port0", {we_CPU_0, wrt_addr_0, wrt_data_0}, 22'h0);
      check_eq("idle_port1", {we_CPU_1, wrt_addr_1, wrt_data_1}, 22'h0);
      step();
    end

    // ALU + MEM, distinct addresses: both granted
    alu_req = 1'b1; alu_addr = 5'd3; alu_data = 16'h0003;
    mem_req = 1'b1; mem_addr = 5'd7; mem_data = 16'h0007;
    settle();
    check_eq("dual_gnt", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b1100);
    step();
    alu_req = 1'b0; mem_req = 1'b0;
    check_eq("dual_port0", {we_CPU_0, wrt_addr_0, wrt_data_0}, {1'b1, 5'd3, 16'h0003});
    check_eq("dual_port1", {we_CPU_1, wrt_addr_1, wrt_data_1}, {1'b1, 5'd7, 16'h0007});

    // ALU + VPU to the same register: serialised, ALU first
    alu_req = 1'b1; alu_addr = 5'd5; alu_data = 16'hAAAA;
    vpu_req = 1'b1; vpu_addr = 5'd5; vpu_data = 16'h5555;
    settle();
    check_eq("same_addr_c1", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b1001);
    step();
    alu_req = 1'b0;
    settle();
    check_eq("same_addr_c2", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b0010);
    check_eq("same_addr_w1_p0", {we_CPU_0, wrt_addr_0, wrt_data_0}, {1'b1, 5'd5, 16'hAAAA});
    check_eq("same_addr_w1_p1", {we_CPU_1, wrt_addr_1, wrt_data_1}, {1'b0, 5'd7, 16'h0007});
    step();
    vpu_req = 1'b0;
    check_eq("same_addr_w2_p0", {we_CPU_0, wrt_addr_0, wrt_data_0}, {1'b1, 5'd5, 16'h5555});
    check_eq("same_addr_w2_we1", we_CPU_1, 1'b0);
    step();
    check_eq("idle_after_same", {we_CPU_0, we_CPU_1}, 2'b00);

    // Starvation: VPU waits 4 cycles, then wins slot 0 with ALU on slot 1
    alu_req = 1'b1; alu_addr = 5'd1; alu_data = 16'h1001;
    mem_req = 1'b1; mem_addr = 5'd2; mem_data = 16'h2002;
    vpu_req = 1'b1; vpu_addr = 5'd4; vpu_data = 16'h4004;
    for (int c = 1; c <= 4; c++) begin
      settle();
      check_eq($sformatf("starve_wait_c%0d", c), {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b1101);
      step();
    end
    settle();
    check_eq("starve_promote", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b1011);
    step();
    alu_req = 1'b0; mem_req = 1'b0; vpu_req = 1'b0;
    check_eq("starve_port0", {we_CPU_0, wrt_addr_0, wrt_data_0}, {1'b1, 5'd4, 16'h4004});
    check_eq("starve_port1", {we_CPU_1, wrt_addr_1, wrt_data_1}, {1'b1, 5'd1, 16'h1001});
    step();

    // MEM blocked by same-address ALU for two cycles, then reset mid-stream
    alu_req = 1'b1; alu_addr = 5'd6; alu_data = 16'h6666;
    mem_req = 1'b1; mem_addr = 5'd6; mem_data = 16'h7777;
    settle();
    check_eq("pre_rst_c1", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b1001);
    step();
    settle();
    check_eq("pre_rst_c2", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b1001);
    step();
    check_eq("pre_rst_cnt", dut.mem_cnt, 3'd2);
    alu_req = 1'b0;
    rst = 1'b1;
    settle();
    check_eq("rst_gnt_stall", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b0000);
    step();
    rst = 1'b0;
    mem_req = 1'b0;
    check_eq("rst_port0", {we_CPU_0, wrt_addr_0, wrt_data_0}, 22'h0);
    check_eq("rst_port1", {we_CPU_1, wrt_addr_1, wrt_data_1}, 22'h0);
    check_eq("rst_cnt", dut.mem_cnt, 3'd0);
    alu_req = 1'b1; alu_addr = 5'd10; alu_data = 16'h1111;
    mem_req = 1'b1; mem_addr = 5'd11; mem_data = 16'h2222;
    settle();
    check_eq("post_rst_gnt", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b1100);
    step();
    alu_req = 1'b0; mem_req = 1'b0;
    check_eq("post_rst_port0", {we_CPU_0, wrt_addr_0, wrt_data_0}, {1'b1, 5'd10, 16'h1111});
    check_eq("post_rst_port1", {we_CPU_1, wrt_addr_1, wrt_data_1}, {1'b1, 5'd11, 16'h2222});

    // Addresses 9, 9, 12: ALU slot 0, VPU slot 1, MEM deferred one cycle
    alu_req = 1'b1; alu_addr = 5'd9;  alu_data = 16'h0A09;
    mem_req = 1'b1; mem_addr = 5'd9;  mem_data = 16'h0B09;
    vpu_req = 1'b1; vpu_addr = 5'd12; vpu_data = 16'h0C0C;
    settle();
    check_eq("triple_c1", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b1011);
    step();
    alu_req = 1'b0; vpu_req = 1'b0;
    settle();
    check_eq("triple_c2", {alu_gnt, mem_gnt, vpu_gnt, wb_stall}, 4'b0100);
    check_eq("triple_w1_p0", {we_CPU_0, wrt_addr_0, wrt_data_0}, {1'b1, 5'd9, 16'h0A09});
    check_eq("triple_w1_p1", {we_CPU_1, wrt_addr_1, wrt_data_1}, {1'b1, 5'd12, 16'h0C0C});
    step();
    mem_req = 1'b0;
    check_eq("triple_w2_p0", {we_CPU_0, wrt_addr_0, wrt_data_0}, {1'b1, 5'd9, 16'h0B09});
    check_eq("triple_w2_p1", {we_CPU_1, wrt_addr_1, wrt_data_1}, {1'b0, 5'd12, 16'h0C0C});
    step();
    check_eq("final_idle", {we_CPU_0, we_CPU_1, wb_stall}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
